// File: rtl/piano_pkg.sv
// ============================================================================
//  Module      : piano_pkg
//  Description : Shared types, note indices and helpers for the note arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package piano_pkg;

    localparam int NUM_NOTES = 8;

    typedef logic [2:0] note_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ATTACK = 2'd1,
        PLAY   = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam note_idx_t C4 = 3'd0;
    localparam note_idx_t D4 = 3'd1;
    localparam note_idx_t E4 = 3'd2;
    localparam note_idx_t F4 = 3'd3;
    localparam note_idx_t G4 = 3'd4;
    localparam note_idx_t A4 = 3'd5;
    localparam note_idx_t B4 = 3'd6;
    localparam note_idx_t C5 = 3'd7;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic note_idx_t lowest_idx(input logic [NUM_NOTES-1:0] v);
        note_idx_t r;
        r = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (v[i]) r = note_idx_t'(i);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
//  Module      : key_debounce
//  Description : One-bit 2-flop synchroniser followed by a stability filter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_key,
    output logic o_key
);

    localparam int c_CNT_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;

    // A new level is accepted only after it has differed from the
    // accepted level for DEBOUNCE_CYC consecutive cycles.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_W'(DEBOUNCE_CYC - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_key = r_level;

endmodule

`default_nettype wire

// File: rtl/note_arbiter.sv
// ============================================================================
//  Module      : note_arbiter
//  Description : Last-pressed-wins speaker arbiter for 8 piano keys with a
//                minimum note hold and a silent gap after the final release.
//                Optional key debounce: define NOTE_ARBITER_DEBOUNCE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module note_arbiter
    import piano_pkg::*;
#(
    parameter int MIN_HOLD     = 2_500_000,
    parameter int GAP_CYC      = 1_000_000,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int CNT_W        = 22
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NUM_NOTES-1:0] i_key,
    input  logic [NUM_NOTES-1:0] i_note_clk,
    output logic                 o_speaker,
    output note_idx_t            o_note_sel,
    output logic                 o_note_valid,
    output logic                 o_busy
);

    localparam logic [CNT_W-1:0] c_HOLD_LOAD = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] c_GAP_LOAD  = CNT_W'(GAP_CYC - 1);

    logic [NUM_NOTES-1:0] w_key_in;

`ifdef NOTE_ARBITER_DEBOUNCE_EN
    generate
        for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_debounce
            key_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_key_debounce (
                .i_clk     (i_clk),
                .i_reset_n (i_reset_n),
                .i_key     (i_key[gi]),
                .o_key     (w_key_in[gi])
            );
        end
    endgenerate
`else
    assign w_key_in = i_key;
`endif

    logic [NUM_NOTES-1:0] r_key_s;
    logic [NUM_NOTES-1:0] r_key_d;
    state_t               r_state;
    note_idx_t            r_sel;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_pend_vld;
    note_idx_t            r_pend_idx;
    logic                 r_speaker;

    state_t               w_state_nx;
    note_idx_t            w_sel_nx;
    logic [CNT_W-1:0]     w_cnt_nx;
    logic                 w_pend_vld_nx;
    note_idx_t            w_pend_idx_nx;
    logic                 w_valid;
    logic                 w_busy;

    logic [NUM_NOTES-1:0] w_rise;
    logic                 w_any_rise;
    note_idx_t            w_rise_idx;
    note_idx_t            w_held_idx;
    logic                 w_active_held;
    logic                 w_pend_eff_vld;
    note_idx_t            w_pend_eff_idx;

    assign w_rise         = r_key_s & ~r_key_d;
    assign w_any_rise     = |w_rise;
    assign w_rise_idx     = lowest_idx(w_rise);
    assign w_held_idx     = lowest_idx(r_key_s);
    assign w_active_held  = r_key_s[r_sel];
    // A rise landing on the expiry cycle counts as the newest pending key.
    assign w_pend_eff_vld = r_pend_vld | w_any_rise;
    assign w_pend_eff_idx = w_any_rise ? w_rise_idx : r_pend_idx;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_key_s    <= '0;
            r_key_d    <= '0;
            r_state    <= IDLE;
            r_sel      <= C4;
            r_cnt      <= '0;
            r_pend_vld <= 1'b0;
            r_pend_idx <= C4;
            r_speaker  <= 1'b0;
        end else begin
            r_key_s    <= w_key_in;
            r_key_d    <= r_key_s;
            r_state    <= w_state_nx;
            r_sel      <= w_sel_nx;
            r_cnt      <= w_cnt_nx;
            r_pend_vld <= w_pend_vld_nx;
            r_pend_idx <= w_pend_idx_nx;
            r_speaker  <= w_valid ? i_note_clk[r_sel] : 1'b0;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_sel_nx      = r_sel;
        w_cnt_nx      = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
        w_pend_vld_nx = r_pend_vld;
        w_pend_idx_nx = r_pend_idx;
        case (r_state)
            IDLE: begin
                if (w_any_rise) begin
                    w_state_nx    = ATTACK;
                    w_sel_nx      = w_rise_idx;
                    w_cnt_nx      = c_HOLD_LOAD;
                    w_pend_vld_nx = 1'b0;
                end
            end
            ATTACK: begin
                if (w_any_rise) begin
                    w_pend_vld_nx = 1'b1;
                    w_pend_idx_nx = w_rise_idx;
                end
                if (r_cnt == '0) begin
                    w_pend_vld_nx = 1'b0;
                    if (w_pend_eff_vld && r_key_s[w_pend_eff_idx]) begin
                        w_state_nx = ATTACK;
                        w_sel_nx   = w_pend_eff_idx;
                        w_cnt_nx   = c_HOLD_LOAD;
                    end else if (w_active_held) begin
                        w_state_nx = PLAY;
                    end else if (|r_key_s) begin
                        w_state_nx = ATTACK;
                        w_sel_nx   = w_held_idx;
                        w_cnt_nx   = c_HOLD_LOAD;
                    end else begin
                        w_state_nx = GAP;
                        w_cnt_nx   = c_GAP_LOAD;
                    end
                end
            end
            PLAY: begin
                if (w_any_rise) begin
                    w_state_nx    = ATTACK;
                    w_sel_nx      = w_rise_idx;
                    w_cnt_nx      = c_HOLD_LOAD;
                    w_pend_vld_nx = 1'b0;
                end else if (!w_active_held) begin
                    if (|r_key_s) begin
                        w_state_nx    = ATTACK;
                        w_sel_nx      = w_held_idx;
                        w_cnt_nx      = c_HOLD_LOAD;
                        w_pend_vld_nx = 1'b0;
                    end else begin
                        w_state_nx = GAP;
                        w_cnt_nx   = c_GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (w_any_rise) begin
                    w_state_nx    = ATTACK;
                    w_sel_nx      = w_rise_idx;
                    w_cnt_nx      = c_HOLD_LOAD;
                    w_pend_vld_nx = 1'b0;
                end else if (r_cnt == '0) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        w_valid = (r_state == ATTACK) || (r_state == PLAY);
        w_busy  = (r_state != IDLE);
    end

    assign o_speaker    = r_speaker;
    assign o_note_sel   = r_sel;
    assign o_note_valid = w_valid;
    assign o_busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_note_arbiter.sv
// ============================================================================
//  Module      : tb_note_arbiter
//  Description : Directed scoreboard bench for note_arbiter (small parameters).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_note_arbiter;

`ifdef NOTE_ARBITER_DEBOUNCE_EN
    localparam int LAT = 4;
    localparam int TAP = 2;
`else
    localparam int LAT = 0;
    localparam int TAP = 1;
`endif

    typedef struct {
        int         cyc;
        logic [2:0] sel;
        logic       valid;
        logic       busy;
        logic       force0;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_reset_n;
    logic [7:0] i_key;
    logic [7:0] i_note_clk;
    logic       o_speaker;
    logic [2:0] o_note_sel;
    logic       o_note_valid;
    logic       o_busy;

    int   ecnt   = 0;
    int   base   = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    note_arbiter #(
        .MIN_HOLD     (4),
        .GAP_CYC      (3),
        .DEBOUNCE_CYC (2),
        .CNT_W        (22)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (i_reset_n),
        .i_key        (i_key),
        .i_note_clk   (i_note_clk),
        .o_speaker    (o_speaker),
        .o_note_sel   (o_note_sel),
        .o_note_valid (o_note_valid),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic logic [7:0] nclk(input int n);
        logic [7:0] v;
        v = 8'(n);
        return (v * 8'd37) ^ {v[1:0], v[7:2]};
    endfunction

    always @(negedge clk) i_note_clk = nclk(ecnt);

    function automatic int sh(input int x);
        return (x < 2) ? x : x + LAT;
    endfunction

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops every expectation due this cycle and compares.
    exp_t prev;
    bit   have_prev = 1'b0;
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] nc;
        logic       es;
        while (q.size() > 0 && q[0].cyc <= ecnt) begin
            e = q.pop_front();
            if (e.cyc < ecnt) begin
                chk("missed_sample", e.cyc, ecnt, e.cyc);
            end else begin
                chk("note_valid", ecnt, int'(o_note_valid), int'(e.valid));
                chk("busy", ecnt, int'(o_busy), int'(e.busy));
                if (e.valid || e.force0)
                    chk("note_sel", ecnt, int'(o_note_sel), int'(e.sel));
                if (e.force0) begin
                    chk("speaker_silent", ecnt, int'(o_speaker), 0);
                end else if (have_prev && prev.cyc == ecnt - 1) begin
                    nc = nclk(ecnt - 1);
                    es = prev.valid ? nc[prev.sel] : 1'b0;
                    chk("speaker", ecnt, int'(o_speaker), int'(es));
                end
            end
            prev      = e;
            have_prev = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [7:0] k, input int n);
        i_key = k;
        repeat (n) step();
    endtask

    task automatic do_reset();
        i_key     = 8'h00;
        i_reset_n = 1'b0;
        step();
        step();
        i_reset_n = 1'b1;
        base      = ecnt;
    endtask

    task automatic ex0();
        for (int i = 0; i <= 1 + LAT; i++)
            q.push_back('{base + i, 3'd0, 1'b0, 1'b0, (i == 0)});
    endtask

    task automatic ex(input int a, input int b, input logic [2:0] sel,
                      input logic v, input logic bz);
        for (int i = sh(a); i <= sh(b); i++)
            q.push_back('{base + i, sel, v, bz, 1'b0});
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_key     = 8'h00;

        // Single key: attack, play, release through the gap to idle.
        do_reset();
        ex0(); ex(2, 11, 3'd2, 1, 1); ex(12, 14, 3'd2, 0, 1); ex(15, 16, 3'd2, 0, 0);
        hold(8'h04, 10); hold(8'h00, 7 + LAT);

        // Newer key preempts PLAY; releasing it falls back to the held key.
        do_reset();
        ex0(); ex(2, 9, 3'd0, 1, 1); ex(10, 17, 3'd7, 1, 1); ex(18, 24, 3'd0, 1, 1);
        ex(25, 27, 3'd0, 0, 1); ex(28, 29, 3'd0, 0, 0);
        hold(8'h01, 8); hold(8'h81, 8); hold(8'h01, 7); hold(8'h00, 7 + LAT);

        // Press during ATTACK is deferred; also on the expiry cycle itself.
        for (int p = 3; p <= 4; p++) begin
            do_reset();
            ex0(); ex(2, 5, 3'd4, 1, 1); ex(6, 13, 3'd1, 1, 1);
            ex(14, 16, 3'd1, 0, 1); ex(17, 18, 3'd1, 0, 0);
            hold(8'h10, p); hold(8'h12, 12 - p); hold(8'h00, 7 + LAT);
        end

        // Simultaneous rises: lowest index wins.
        do_reset();
        ex0(); ex(2, 9, 3'd1, 1, 1); ex(10, 12, 3'd1, 0, 1); ex(13, 14, 3'd1, 0, 0);
        hold(8'h0A, 8); hold(8'h00, 7 + LAT);

        // Short tap still plays the full hold; a press in GAP attacks at once.
        do_reset();
        ex0(); ex(2, 5, 3'd5, 1, 1); ex(6, 7, 3'd5, 0, 1); ex(8, 15, 3'd3, 1, 1);
        ex(16, 18, 3'd3, 0, 1); ex(19, 20, 3'd3, 0, 0);
        hold(8'h20, TAP); hold(8'h00, 6 - TAP); hold(8'h08, 8); hold(8'h00, 7 + LAT);

        // Reset mid-note silences everything on the next edge.
        do_reset();
        ex0(); ex(2, 8, 3'd2, 1, 1);
        q.push_back('{base + sh(9), 3'd0, 1'b0, 1'b0, 1'b1});
`ifndef NOTE_ARBITER_DEBOUNCE_EN
        ex(10, 10, 3'd0, 0, 0); ex(11, 13, 3'd2, 1, 1);
`endif
        hold(8'h04, 8 + LAT);
        i_reset_n = 1'b0;
        step();
        i_reset_n = 1'b1;
        hold(8'h04, 5);

`ifdef NOTE_ARBITER_DEBOUNCE_EN
        // A one-cycle glitch never becomes a note.
        do_reset();
        ex0(); ex(2, 12, 3'd0, 0, 0);
        hold(8'h40, 1); hold(8'h00, 13);
`endif

        hold(8'h00, 3);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("unchecked_expectation", e.cyc, ecnt, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
